// File: rtl/converter_if.sv
// Character stream into the converter and the per-packet result back out.
// The source drives data/sop/eop; the converter drives number/valid/error.
interface converter_if #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 64
);
   logic [INPUT_WIDTH-1:0]  data;
   logic                    sop;
   logic                    eop;
   logic [OUTPUT_WIDTH-1:0] number;
   logic                    valid;
   logic                    error;

   modport master (output data, sop, eop, input number, valid, error);
   modport slave  (input data, sop, eop, output number, valid, error);
endinterface

// File: rtl/converter.sv
// Packetised ASCII-to-binary converter: the sop beat sets the radix, digit beats
// accumulate most-significant first, and the result is reported one cycle after eop.
module converter #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 64
) (
   input logic        clk,
   input logic        rst,
   converter_if.slave bus
);
   localparam int WW = OUTPUT_WIDTH + 6;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state;
   logic [5:0]              radix;
   logic [OUTPUT_WIDTH-1:0] acc;
   logic                    errflag;
   logic                    gotdigit;

   logic [7:0]              ch;
   logic [5:0]              value;
   logic                    charok;
   logic [WW-1:0]           wide;
   logic                    digitok;
   logic                    radixbad;
   logic                    nexterr;
   logic                    nextgot;
   logic                    resulterr;
   logic [OUTPUT_WIDTH-1:0] nextacc;

   // Digit decode and the widened multiply-add; any carry above the result
   // width means the value no longer fits and the packet is flagged instead of wrapping.
   always_comb begin
      ch     = bus.data[7:0];
      value  = '0;
      charok = 1'b0;
      if (ch >= 8'd48 && ch <= 8'd57) begin
         value  = 6'(ch - 8'd48);
         charok = 1'b1;
      end else if (ch >= 8'd65 && ch <= 8'd90) begin
         value  = 6'(ch - 8'd55);
         charok = 1'b1;
      end else if (ch >= 8'd97 && ch <= 8'd122) begin
         value  = 6'(ch - 8'd87);
         charok = 1'b1;
      end
      wide      = WW'(acc) * WW'(radix) + WW'(value);
      digitok   = charok && (value < radix) && (wide[WW-1:OUTPUT_WIDTH] == '0)
                  && (bus.data[INPUT_WIDTH-1:8] == '0);
      radixbad  = (bus.data < INPUT_WIDTH'(2)) || (bus.data > INPUT_WIDTH'(36));
      nexterr   = errflag || !digitok;
      nextgot   = gotdigit || digitok;
      nextacc   = digitok ? wide[OUTPUT_WIDTH-1:0] : acc;
      resulterr = nexterr || !nextgot;
   end

   // A sop beat always restarts, silently discarding any packet in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         radix      <= '0;
         acc        <= '0;
         errflag    <= 1'b0;
         gotdigit   <= 1'b0;
         bus.number <= '0;
         bus.valid  <= 1'b0;
         bus.error  <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         bus.error <= 1'b0;
         if (bus.sop) begin
            radix    <= bus.data[5:0];
            acc      <= '0;
            gotdigit <= 1'b0;
            errflag  <= radixbad;
            if (bus.eop) begin
               bus.valid  <= 1'b1;
               bus.error  <= 1'b1;
               bus.number <= '0;
               state      <= IDLE;
            end else begin
               state <= ACTIVE;
            end
         end else if (state == ACTIVE) begin
            acc      <= nextacc;
            errflag  <= nexterr;
            gotdigit <= nextgot;
            if (bus.eop) begin
               bus.valid  <= 1'b1;
               bus.error  <= resulterr;
               bus.number <= resulterr ? '0 : nextacc;
               state      <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_converter.sv
// Directed bench for converter: a packet-level atoi model predicts the outputs every
// cycle, and literal expectations pin the results of the hand-worked packets.
module tb_converter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   converter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(64)) bus ();

   converter #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [63:0] expNumber = '0;
   logic        expValid  = 1'b0;
   logic        expError  = 1'b0;
   logic        inPkt     = 1'b0;
   int unsigned pktRadix  = 0;
   logic [15:0] pktChars[$];
   logic [64:0] resQ[$];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int unsigned charValue(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "A" && c <= "Z") return int'(c) - 55;
      if (c >= "a" && c <= "z") return int'(c) - 87;
      return 99;
   endfunction

   // Whole-packet atoi with an overflow test done by comparison against the limit.
   function automatic void modelAtoi(input int unsigned radix, input logic [15:0] chars[$],
                                     output logic err, output logic [63:0] num);
      longint unsigned acc = 0;
      int unsigned     v;
      int              cnt = 0;
      err = (radix < 2) || (radix > 36);
      foreach (chars[i]) begin
         if (chars[i][15:8] != 8'h00) err = 1'b1;
         v = charValue(chars[i][7:0]);
         if (v >= radix) err = 1'b1;
         else if (acc > (64'hFFFF_FFFF_FFFF_FFFF - 64'(v)) / 64'(radix)) err = 1'b1;
         else begin
            acc = acc * radix + v;
            cnt++;
         end
      end
      if (cnt == 0) err = 1'b1;
      num = err ? 64'd0 : acc;
   endfunction

   // Predict what the outputs hold after each rising edge from the beat just sampled.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         expNumber = '0;
         expValid  = 1'b0;
         expError  = 1'b0;
         inPkt     = 1'b0;
         pktChars.delete();
      end else begin
         expValid = 1'b0;
         expError = 1'b0;
         if (bus.sop) begin
            pktRadix = int'(bus.data);
            pktChars.delete();
            inPkt = 1'b1;
            if (bus.eop) begin
               expValid  = 1'b1;
               expError  = 1'b1;
               expNumber = '0;
               inPkt     = 1'b0;
            end
         end else if (inPkt) begin
            pktChars.push_back(bus.data);
            if (bus.eop) begin
               modelAtoi(pktRadix, pktChars, expError, expNumber);
               expValid = 1'b1;
               inPkt    = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         checkOutput("cycle valid", 64'(bus.valid), 64'(expValid));
         checkOutput("cycle error", 64'(bus.error), 64'(expError));
         checkOutput("cycle number", bus.number, expNumber);
         if (bus.valid) resQ.push_back({bus.error, bus.number});
      end
   end

   task automatic applyStimulus(input logic [15:0] d, input logic s, input logic e);
      @(posedge clk);
      #1;
      bus.data = d;
      bus.sop  = s;
      bus.eop  = e;
   endtask

   task automatic idle();
      applyStimulus(16'd0, 1'b0, 1'b0);
   endtask

   task automatic sendPacket(input logic [15:0] radix, input string s);
      applyStimulus(radix, 1'b1, 1'b0);
      for (int i = 0; i < s.len(); i++)
         applyStimulus({8'h00, s[i]}, 1'b0, i == s.len() - 1);
   endtask

   task automatic expectResult(input string name, input logic expErr, input logic [63:0] expNum);
      logic [64:0] r;
      for (int i = 0; i < 20 && resQ.size() == 0; i++) @(negedge clk);
      if (resQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: no result, expected error=%0d number=%0d", name, expErr, expNum);
      end else begin
         r = resQ.pop_front();
         checkOutput({name, " error"}, 64'(r[64]), 64'(expErr));
         checkOutput({name, " number"}, r[63:0], expNum);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: bench did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.data = '0;
      bus.sop  = 1'b0;
      bus.eop  = 1'b0;
      #1 rst = 1'b0;
      #10;
      checkOutput("reset valid", 64'(bus.valid), 64'd0);
      checkOutput("reset error", 64'(bus.error), 64'd0);
      checkOutput("reset number", bus.number, 64'd0);
      #11 rst = 1'b1;

      sendPacket(16'd10, "163"); idle();
      expectResult("radix10 163", 1'b0, 64'd163);

      sendPacket(16'd12, ";72");
      sendPacket(16'd8, "7777"); idle();
      expectResult("radix12 bad char", 1'b1, 64'd0);
      expectResult("radix8 back-to-back", 1'b0, 64'd4095);

      sendPacket(16'd10, "1:9"); idle();
      expectResult("radix10 colon", 1'b1, 64'd0);
      sendPacket(16'd16, "1aF"); idle();
      expectResult("radix16 1aF", 1'b0, 64'd431);
      sendPacket(16'd1, "0"); idle();
      expectResult("radix 1", 1'b1, 64'd0);
      sendPacket(16'd37, "1"); idle();
      expectResult("radix 37", 1'b1, 64'd0);
      sendPacket(16'd36, "zZ"); idle();
      expectResult("radix36 zZ", 1'b0, 64'd1295);
      sendPacket(16'd2, "101"); idle();
      expectResult("radix2 101", 1'b0, 64'd5);
      sendPacket(16'd10, "-5"); idle();
      expectResult("minus sign", 1'b1, 64'd0);

      applyStimulus(16'd10, 1'b1, 1'b0);
      applyStimulus(16'h0131, 1'b0, 1'b1); idle();
      expectResult("high byte set", 1'b1, 64'd0);

      sendPacket(16'd16, "FFFFFFFFFFFFFFFF"); idle();
      expectResult("radix16 max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      sendPacket(16'd16, "FFFFFFFFFFFFFFFFF"); idle();
      expectResult("radix16 overflow", 1'b1, 64'd0);

      applyStimulus(16'd10, 1'b1, 1'b1); idle();
      expectResult("empty packet", 1'b1, 64'd0);

      applyStimulus(16'd10, 1'b1, 1'b0);
      applyStimulus(16'h0039, 1'b0, 1'b0);
      sendPacket(16'd10, "42"); idle();
      expectResult("abort restart", 1'b0, 64'd42);

      sendPacket(16'd16, "1aF"); idle();
      expectResult("before reset", 1'b0, 64'd431);
      applyStimulus(16'd10, 1'b1, 1'b0);
      applyStimulus(16'h0035, 1'b0, 1'b0);
      #3 rst = 1'b0;
      #1;
      checkOutput("mid reset valid", 64'(bus.valid), 64'd0);
      checkOutput("mid reset error", 64'(bus.error), 64'd0);
      checkOutput("mid reset number", bus.number, 64'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      applyStimulus(16'h0037, 1'b0, 1'b1); idle();
      repeat (4) @(negedge clk);
      checkOutput("no result after reset", 64'(resQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
